// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: state encoding and sizing helpers shared by the sequential multiplier
package seq_mult_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_DONE = 3'd2,
    S_ERR  = 3'd3,
    S_NEG  = 3'd4
  } state_t;
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mult_digit.sv
// mult_digit: combinational unsigned DIGIT x DIGIT multiplier
module mult_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0]   x,
  input  logic [DIGIT-1:0]   y,
  output logic [2*DIGIT-1:0] p
);
  assign p = {{DIGIT{1'b0}}, x} * {{DIGIT{1'b0}}, y};
endmodule

// File: rtl/seq_mult_nxn.sv
// seq_mult_nxn: digit-serial WIDTHxWIDTH multiplier, one DIGITxDIGIT partial product per clock.
// Define SEQ_MULT_SIGNED_MODE_EN to add the signed_mode input and the NEG (result negate) state.
module seq_mult_nxn
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               reset_a,
  input  logic               start,
`ifdef SEQ_MULT_SIGNED_MODE_EN
  input  logic               signed_mode,
`endif
  input  logic [WIDTH-1:0]   dataa,
  input  logic [WIDTH-1:0]   datab,
  output logic [2*WIDTH-1:0] product_out,
  output logic               done_flag,
  output logic               busy,
  output logic               err_flag,
  output logic [STATE_W-1:0] state_out
);
  localparam int D  = WIDTH / DIGIT;
  localparam int NPP = D * D;
  localparam int KW = cnt_width(NPP);
  localparam int PW = 2 * WIDTH;
  localparam logic [KW-1:0] K_LAST = KW'(NPP - 1);
  if (WIDTH % DIGIT != 0) begin : g_bad_width
    $error("seq_mult_nxn: WIDTH must be a multiple of DIGIT");
  end
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, a_in, b_in;
  logic [PW-1:0] acc_q, acc_d, pp_sh;
  logic [KW-1:0] k_q, k_d;
  logic neg_q, neg_d, neg_in;
  logic done_q, busy_q, err_q;
  logic [DIGIT-1:0] da, db;
  logic [2*DIGIT-1:0] pp;
  // step k walks a-digits fastest: i = k mod D, j = k div D
  assign da = a_q[(32'(k_q) % D) * DIGIT +: DIGIT];
  assign db = b_q[(32'(k_q) / D) * DIGIT +: DIGIT];
  assign pp_sh = PW'(pp) << ((32'(k_q) % D + 32'(k_q) / D) * DIGIT);
  mult_digit #(.DIGIT(DIGIT)) u_mul (.x(da), .y(db), .p(pp));
`ifdef SEQ_MULT_SIGNED_MODE_EN
  // magnitudes are multiplied unsigned; -2^(WIDTH-1) still fits as a WIDTH-bit magnitude
  assign a_in   = (signed_mode && dataa[WIDTH-1]) ? -dataa : dataa;
  assign b_in   = (signed_mode && datab[WIDTH-1]) ? -datab : datab;
  assign neg_in = signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
`else
  assign a_in   = dataa;
  assign b_in   = datab;
  assign neg_in = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    k_d     = k_q;
    neg_d   = neg_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        a_d     = a_in;
        b_d     = b_in;
        neg_d   = neg_in;
        acc_d   = '0;
        k_d     = '0;
        state_d = S_CALC;
      end
      S_CALC: if (start) begin
        acc_d   = '0;
        state_d = S_ERR;
      end else begin
        acc_d = acc_q + pp_sh;
        k_d   = k_q + KW'(1);
        if (k_q == K_LAST) state_d = neg_q ? S_NEG : S_DONE;
      end
      S_NEG: if (start) begin
        acc_d   = '0;
        state_d = S_ERR;
      end else begin
        acc_d   = -acc_q;
        state_d = S_DONE;
      end
      S_ERR:   state_d = start ? S_ERR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      neg_q   <= neg_d;
      done_q  <= state_d == S_DONE;
      busy_q  <= state_d == S_CALC || state_d == S_NEG;
      err_q   <= state_d == S_ERR;
    end
  end
  assign product_out = acc_q;
  assign done_flag   = done_q;
  assign busy        = busy_q;
  assign err_flag    = err_q;
  assign state_out   = state_q;
endmodule

// File: tb/tb_seq_mult_nxn.sv
// tb_seq_mult_nxn: scoreboard bench for seq_mult_nxn (8x8 and 16x16 instances)
module tb_seq_mult_nxn;
  typedef struct {
    logic [31:0] p;
    int          t;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic reset_a, start, start16, sm, seen_neg;
  logic [7:0] dataa, datab;
  logic [15:0] da16, db16;
  logic [15:0] prod;
  logic [31:0] prod16;
  logic done, busy, err, done16, busy16, err16;
  logic [2:0] st, st16;
  logic d8p = 1'b0, d16p = 1'b0;
  int checks = 0, failures = 0, cyc = 0;
  exp_t q8[$], q16[$];
  exp_t e8, e16;

  seq_mult_nxn #(.WIDTH(8), .DIGIT(4)) u8 (
    .clk(clk), .reset_a(reset_a), .start(start),
`ifdef SEQ_MULT_SIGNED_MODE_EN
    .signed_mode(sm),
`endif
    .dataa(dataa), .datab(datab), .product_out(prod), .done_flag(done),
    .busy(busy), .err_flag(err), .state_out(st)
  );
  seq_mult_nxn #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .reset_a(reset_a), .start(start16),
`ifdef SEQ_MULT_SIGNED_MODE_EN
    .signed_mode(1'b0),
`endif
    .dataa(da16), .datab(db16), .product_out(prod16), .done_flag(done16),
    .busy(busy16), .err_flag(err16), .state_out(st16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done && !d8p) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done8: got product 0x%0h expected no result", prod);
      end else begin
        e8 = q8.pop_front();
        chk("product8", 32'(prod), e8.p);
        chk("latency8", cyc - e8.t, e8.lat);
      end
    end
    d8p <= done;
  end

  always @(negedge clk) begin
    if (done16 && !d16p) begin
      if (q16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done16: got product 0x%0h expected no result", prod16);
      end else begin
        e16 = q16.pop_front();
        chk("product16", prod16, e16.p);
        chk("latency16", cyc - e16.t, e16.lat);
      end
    end
    d16p <= done16;
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [31:0] p, input int lat);
    @(negedge clk);
    dataa = a;
    datab = b;
    sm    = s;
    start = 1'b1;
    q8.push_back('{p, cyc + 1, lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait8(input int lim);
    int n = 0;
    seen_neg = 1'b0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
      if (st == 3'd4) seen_neg = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout8: done_flag got 0 expected 1 within %0d cycles", lim);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [31:0] p, input int lat);
    issue8(a, b, s, p, lat);
    wait8(lat + 4);
  endtask

  initial begin
    int n, bc;
    reset_a = 1'b1; start = 1'b0; start16 = 1'b0; sm = 1'b0; seen_neg = 1'b0;
    dataa = '0; datab = '0; da16 = '0; db16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_prod", 32'(prod), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_state", 32'(st), 0);
    chk("rst_prod16", prod16, 0);
    reset_a = 1'b0;
    run8(8'hFF, 8'hFF, 1'b0, 32'hFE01, 4);
    chk("state_done", 32'(st), 2);
    repeat (3) @(negedge clk);
    chk("hold_prod", 32'(prod), 32'hFE01);
    chk("hold_done", 32'(done), 1);
    issue8(8'h00, 8'hA5, 1'b0, 32'h0000, 4);
    chk("acc_cleared", 32'(prod), 0);
    chk("busy_calc", 32'(busy), 1);
    wait8(8);
    run8(8'h0C, 8'h0D, 1'b0, 32'h009C, 4);
    // start reasserted during the second CALC cycle aborts into ERR
    @(negedge clk); dataa = 8'h05; datab = 8'h07; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    chk("err_flag", 32'(err), 1);
    chk("err_state", 32'(st), 3);
    chk("err_prod", 32'(prod), 0);
    chk("err_busy", 32'(busy), 0);
    @(negedge clk);
    chk("err_stay", 32'(st), 3);
    start = 1'b0;
    @(negedge clk);
    chk("err_to_idle", 32'(st), 0);
    chk("err_cleared", 32'(err), 0);
    // asynchronous reset between edges while a product is accumulating
    @(negedge clk); dataa = 8'h77; datab = 8'h99; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #2 reset_a = 1'b1;
    #1;
    chk("arst_prod", 32'(prod), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_state", 32'(st), 0);
    @(negedge clk); reset_a = 1'b0;
    run8(8'h12, 8'h34, 1'b0, 32'h03A8, 4);
    @(negedge clk); da16 = 16'hFFFF; db16 = 16'hFFFF; start16 = 1'b1;
    q16.push_back('{32'hFFFE0001, cyc + 1, 16});
    @(negedge clk); start16 = 1'b0;
    bc = busy16 ? 1 : 0;
    n = 0;
    while (!done16 && n < 40) begin
      @(negedge clk);
      n++;
      if (busy16) bc++;
    end
    chk("done16_seen", 32'(done16), 1);
    chk("busy16_cycles", bc, 16);
`ifdef SEQ_MULT_SIGNED_MODE_EN
    run8(8'h80, 8'hFF, 1'b1, 32'h0080, 4);
    chk("pos_no_neg", 32'(seen_neg), 0);
    run8(8'h80, 8'h01, 1'b1, 32'hFF80, 5);
    chk("neg_seen", 32'(seen_neg), 1);
    run8(8'h80, 8'h80, 1'b1, 32'h4000, 4);
`endif
    repeat (2) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got stuck, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/seq_mult_nxn.md
Name: seq_mult_nxn

Overview:
Parametrised sequential NxN multiplier, successor to the fixed 8x8 digit-serial multiplier. Operands are split into DIGIT-bit digits. One DIGIT x DIGIT partial product is computed per clock, shifted, and accumulated into a 2*WIDTH-bit register. Adds a busy flag, an explicit error state, a state code for the seven-segment controller, and an optional signed mode.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of DIGIT.
DIGIT, 4, digit width in bits; D = WIDTH/DIGIT digits per operand; D*D partial products per operation.

Ports:
clk  input  1  rising-edge clock
reset_a  input  1  asynchronous reset, active-high
start  input  1  level request; sampled on each rising edge
dataa  input  WIDTH  multiplicand; latched when start is accepted
datab  input  WIDTH  multiplier; latched when start is accepted
product_out  output  2*WIDTH  accumulator/result register
done_flag  output  1  high while in DONE
busy  output  1  high while in CALC (and NEG if enabled)
err_flag  output  1  high while in ERR
state_out  output  3  current state code, for seven_segment_cntrl

Behaviour:
- Reset, asynchronous, any state: state=IDLE, product_out=0, done_flag=0, busy=0, err_flag=0, step counter=0, operand registers=0.
- State codes (state_out): IDLE=0, CALC=1, DONE=2, ERR=3, NEG=4.
- IDLE or DONE with start=1:
  - latch dataa/datab
  - clear accumulator
  - step k=0
  - go to CALC
- IDLE with start=0: stay. DONE with start=0: stay; product_out holds.
- CALC, each cycle:
  - i = k mod D, j = k div D
  - pp = a[i*DIGIT +: DIGIT] * b[j*DIGIT +: DIGIT], 2*DIGIT bits, unsigned
  - acc += pp << ((i+j)*DIGIT), 2*WIDTH bits; no overflow possible
  - k++
  - on k = D*D-1: go to DONE (or NEG, see optional feature)
- Latency: done_flag rises D*D rising edges after the edge that accepted start. That is 4 for the default, 16 for WIDTH=16.
- start=1 during CALC (any cycle after the accepting edge): go to ERR.
  - accumulator cleared
  - busy=0, err_flag=1
  - operation aborted
- Start must therefore be a pulse, deasserted the cycle after acceptance.
- ERR: stay while start=1; go to IDLE on the first edge with start=0.
- product_out is exactly the accumulator register: partial sums are visible during CALC and valid only when done_flag=1.
- done_flag, busy, err_flag and state_out are registered and mutually exclusive.
- Reset asserted mid-CALC: immediate return to reset values; no partial result retained.
- Counter width: clog2(D*D), minimum 1 bit.
- Elaboration error if WIDTH % DIGIT != 0.

Optional Feature:
SEQ_MULT_SIGNED_MODE_EN
- Defined:
  - adds input port signed_mode (1 bit), sampled with start
  - if signed_mode=1: absolute values of dataa/datab are latched and neg = sign(a) xor sign(b) is registered
  - after the last CALC step: go to NEG if neg=1, where product_out <= -acc (two's complement, 2*WIDTH bits) for one cycle, then DONE; otherwise go straight to DONE
  - signed latency: D*D, or D*D+1 when the result is negative
  - most negative operand: -2^(WIDTH-1) magnitude fits unsigned in WIDTH bits; (-128)*(-128)=16384 is exact
  - start during NEG goes to ERR, same as CALC
- Undefined: no signed_mode port, NEG state unreachable, unsigned only.

Decomposition:
- Package seq_mult_pkg:
  - state typedef (3-bit enum IDLE/CALC/DONE/ERR/NEG with the codes above)
  - a STATE_W=3 constant
  - a clog2-based function for the counter width
- One sub-module, mult_digit: combinational DIGIT x DIGIT unsigned multiplier, parametrised by DIGIT, instantiated once.
- Muxing, shifting, accumulation and FSM stay in seq_mult_nxn.

Test Plan:
- WIDTH=8: start pulse with dataa=0xFF, datab=0xFF -> done_flag high 4 edges later, product_out=0xFE01, state_out=2; holds while start=0.
- WIDTH=8: 0x00 x 0xA5 -> 0x0000. Then back-to-back from DONE with 0x0C x 0x0D -> 0x009C; accumulator cleared between runs.
- Start reasserted on the 2nd CALC cycle -> err_flag=1, state_out=3, product_out=0; start low -> IDLE next edge.
- reset_a pulsed mid-CALC, asynchronous, between edges -> all outputs 0 immediately. A following 0x12 x 0x34 gives 0x03A8.
- WIDTH=16, DIGIT=4: 0xFFFF x 0xFFFF -> 0xFFFE0001 after 16 edges; busy high exactly 16 cycles.
- SEQ_MULT_SIGNED_MODE_EN, signed_mode=1:
  - 0x80 x 0xFF (-128 x -1) -> 0x0080 after 4 edges
  - 0x80 x 0x01 -> 0xFF80 after 5 edges, NEG observed
  - 0x80 x 0x80 -> 0x4000
